// File: rtl/nvdla_glb_gec_req_pipe_if.sv
// CSB request/response channel bundle between the CSB master and the GEC request pipe.
// The pipe sits behind the slave modport; the master modport is the CSB/GEC-side driver view.
interface nvdla_glb_gec_req_pipe_if;
  logic        csb_req_pvld;
  logic        csb_req_prdy;
  logic [62:0] csb_req_pd;
  logic        gec_req_pvld;
  logic        gec_req_prdy;
  logic [62:0] gec_req_pd;
  logic        gec_resp_valid;
  logic [33:0] gec_resp_pd;
  logic        csb_resp_valid;
  logic [33:0] csb_resp_pd;

  modport slave (
    input  csb_req_pvld, csb_req_pd, gec_req_prdy, gec_resp_valid, gec_resp_pd,
    output csb_req_prdy, gec_req_pvld, gec_req_pd, csb_resp_valid, csb_resp_pd
  );

  modport master (
    output csb_req_pvld, csb_req_pd, gec_req_prdy, gec_resp_valid, gec_resp_pd,
    input  csb_req_prdy, gec_req_pvld, gec_req_pd, csb_resp_valid, csb_resp_pd
  );
endinterface

// File: rtl/nvdla_glb_gec_req_pipe.sv
// CSB->GEC request pipe: 2-entry request FIFO, one outstanding response-expecting
// request at a time, and a timeout that synthesizes an error response.
module nvdla_glb_gec_req_pipe #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  nvdla_glb_gec_req_pipe_if.slave       bus,
  output logic [7:0]                    timeout_cnt
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [62:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        r_type;
  logic [7:0]  r_wait_cnt;
  logic        r_resp_valid;
  logic [33:0] r_resp_pd;
  logic [7:0]  r_tmo_cnt;

  logic [62:0] w_head;
  logic        w_head_exp;
  logic        w_req_prdy;
  logic        w_req_pvld;
  logic        w_push;
  logic        w_pop;
  logic        w_start;
  logic        w_fwd;
  logic        w_tmo;

  // Reads and non-posted writes expect a response; posted writes do not.
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_exp = ~w_head[54] | w_head[55];

  assign w_req_prdy = (r_count != 2'd2);
  assign w_req_pvld = (r_count != 2'd0) && !((r_state == ST_WAIT) && w_head_exp);
  assign w_push     = bus.csb_req_pvld & w_req_prdy;
  assign w_pop      = w_req_pvld & bus.gec_req_prdy;

  assign bus.csb_req_prdy   = w_req_prdy;
  assign bus.gec_req_pvld   = w_req_pvld;
  assign bus.gec_req_pd     = w_head;
  assign bus.csb_resp_valid = r_resp_valid;
  assign bus.csb_resp_pd    = r_resp_pd;
  assign timeout_cnt        = r_tmo_cnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.csb_req_pd;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A response arriving on the timeout cycle wins over the synthesized error.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fwd       = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pop && w_head_exp) begin
          w_start     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.gec_resp_valid) begin
          w_fwd       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_type       <= 1'b0;
      r_wait_cnt   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_pd    <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_type     <= w_head[54];
        r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      r_resp_valid <= w_fwd | w_tmo;
      if (w_fwd) begin
        r_resp_pd <= bus.gec_resp_pd;
      end else if (w_tmo) begin
        r_resp_pd <= {r_type, 1'b1, 32'h0};
      end
      if (w_tmo && (r_tmo_cnt != '1)) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_nvdla_glb_gec_req_pipe.sv
// Directed bench for nvdla_glb_gec_req_pipe with TIMEOUT_CYC=4; expected values hand-derived.
module tb_nvdla_glb_gec_req_pipe;

  logic       clk;
  logic       rstn;
  logic [7:0] timeout_cnt;
  int         n_chk;
  int         n_fail;

  nvdla_glb_gec_req_pipe_if bus_if ();

  nvdla_glb_gec_req_pipe #(.TIMEOUT_CYC(4)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus_if),
    .timeout_cnt     (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] mkpkt(input logic wr, input logic np, input logic [31:0] wdat,
                                        input logic [21:0] addr);
    return {2'b01, 4'hF, 1'b0, np, wr, wdat, addr};
  endfunction

  logic [62:0] p_a, p_b, p_c, p_r1, p_w, p_r2;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    bus_if.csb_req_pvld   = 1'b0;
    bus_if.csb_req_pd     = '0;
    bus_if.gec_req_prdy   = 1'b0;
    bus_if.gec_resp_valid = 1'b0;
    bus_if.gec_resp_pd    = '0;
    tick();
    tick();
    chk("rst_gec_pvld",  bus_if.gec_req_pvld, 0);
    chk("rst_gec_pd",    bus_if.gec_req_pd, 0);
    chk("rst_resp_vld",  bus_if.csb_resp_valid, 0);
    chk("rst_resp_pd",   bus_if.csb_resp_pd, 0);
    chk("rst_tmo_cnt",   timeout_cnt, 0);
    rstn = 1'b1;
    tick();
    chk("rst_prdy", bus_if.csb_req_prdy, 1);

    // Read with response one cycle after pop
    p_a = mkpkt(1'b0, 1'b0, 32'h0, 22'h000123);
    bus_if.gec_req_prdy = 1'b1;
    bus_if.csb_req_pvld = 1'b1;
    bus_if.csb_req_pd   = p_a;
    tick();
    bus_if.csb_req_pvld = 1'b0;
    chk("rd_pvld", bus_if.gec_req_pvld, 1);
    chk("rd_pd",   bus_if.gec_req_pd, {1'b0, p_a});
    tick();
    chk("rd_wait_pvld", bus_if.gec_req_pvld, 0);
    bus_if.gec_resp_valid = 1'b1;
    bus_if.gec_resp_pd    = {2'b00, 32'hDEADBEEF};
    chk("rd_resp_early", bus_if.csb_resp_valid, 0);
    tick();
    bus_if.gec_resp_valid = 1'b0;
    chk("rd_resp_vld", bus_if.csb_resp_valid, 1);
    chk("rd_resp_pd",  bus_if.csb_resp_pd, 34'h0_DEADBEEF);
    tick();
    chk("rd_resp_pulse", bus_if.csb_resp_valid, 0);
    chk("rd_resp_hold",  bus_if.csb_resp_pd, 34'h0_DEADBEEF);

    // Backpressure: three posted writes, FIFO full after two
    p_a = mkpkt(1'b1, 1'b0, 32'h1111_1111, 22'h0000A1);
    p_b = mkpkt(1'b1, 1'b0, 32'h2222_2222, 22'h0000B2);
    p_c = mkpkt(1'b1, 1'b0, 32'h3333_3333, 22'h0000C3);
    bus_if.gec_req_prdy = 1'b0;
    bus_if.csb_req_pvld = 1'b1;
    bus_if.csb_req_pd   = p_a;
    tick();
    chk("bp_prdy1", bus_if.csb_req_prdy, 1);
    bus_if.csb_req_pd = p_b;
    tick();
    chk("bp_prdy2", bus_if.csb_req_prdy, 0);
    chk("bp_head_a", bus_if.gec_req_pd, {1'b0, p_a});
    bus_if.csb_req_pd = p_c;
    tick();
    chk("bp_prdy3", bus_if.csb_req_prdy, 0);
    bus_if.gec_req_prdy = 1'b1;
    tick();
    chk("bp_head_b", bus_if.gec_req_pd, {1'b0, p_b});
    chk("bp_prdy4",  bus_if.csb_req_prdy, 1);
    tick();
    chk("bp_head_c", bus_if.gec_req_pd, {1'b0, p_c});
    chk("bp_pvld_c", bus_if.gec_req_pvld, 1);
    bus_if.csb_req_pvld = 1'b0;
    tick();
    chk("bp_empty",  bus_if.gec_req_pvld, 0);
    chk("bp_noresp", bus_if.csb_resp_valid, 0);

    // Non-posted write timeout: error response 4 cycles after pop
    p_a = mkpkt(1'b1, 1'b1, 32'h5555_5555, 22'h000055);
    bus_if.csb_req_pvld = 1'b1;
    bus_if.csb_req_pd   = p_a;
    tick();
    bus_if.csb_req_pvld = 1'b0;
    chk("to_pvld", bus_if.gec_req_pvld, 1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_quiet", bus_if.csb_resp_valid, 0);
    end
    tick();
    chk("to_vld", bus_if.csb_resp_valid, 1);
    chk("to_pd",  bus_if.csb_resp_pd, 34'h3_0000_0000);
    chk("to_cnt", timeout_cnt, 1);
    tick();
    chk("to_pulse", bus_if.csb_resp_valid, 0);

    // Response coincident with timeout cycle, then a late response in IDLE
    p_a = mkpkt(1'b0, 1'b0, 32'h0, 22'h000077);
    bus_if.csb_req_pvld = 1'b1;
    bus_if.csb_req_pd   = p_a;
    tick();
    bus_if.csb_req_pvld = 1'b0;
    tick();
    tick();
    tick();
    tick();
    bus_if.gec_resp_valid = 1'b1;
    bus_if.gec_resp_pd    = {2'b00, 32'hCAFEF00D};
    tick();
    bus_if.gec_resp_pd = {2'b00, 32'h12345678};
    chk("co_vld", bus_if.csb_resp_valid, 1);
    chk("co_pd",  bus_if.csb_resp_pd, 34'h0_CAFEF00D);
    chk("co_cnt", timeout_cnt, 1);
    tick();
    bus_if.gec_resp_valid = 1'b0;
    chk("late_vld", bus_if.csb_resp_valid, 0);
    chk("late_pd",  bus_if.csb_resp_pd, 34'h0_CAFEF00D);

    // Posted write overtakes while a read waits; second read stalls
    p_r1 = mkpkt(1'b0, 1'b0, 32'h0, 22'h000010);
    p_w  = mkpkt(1'b1, 1'b0, 32'hA5A5_A5A5, 22'h000020);
    p_r2 = mkpkt(1'b0, 1'b0, 32'h0, 22'h000030);
    bus_if.csb_req_pvld = 1'b1;
    bus_if.csb_req_pd   = p_r1;
    tick();
    bus_if.csb_req_pd = p_w;
    chk("pw_r1_pd", bus_if.gec_req_pd, {1'b0, p_r1});
    tick();
    bus_if.csb_req_pd = p_r2;
    chk("pw_w_pvld", bus_if.gec_req_pvld, 1);
    chk("pw_w_pd",   bus_if.gec_req_pd, {1'b0, p_w});
    tick();
    bus_if.csb_req_pvld = 1'b0;
    chk("pw_r2_stall", bus_if.gec_req_pvld, 0);
    chk("pw_r2_pd",    bus_if.gec_req_pd, {1'b0, p_r2});
    tick();
    chk("pw_r2_stall2", bus_if.gec_req_pvld, 0);
    bus_if.gec_resp_valid = 1'b1;
    bus_if.gec_resp_pd    = {2'b00, 32'h0000_0011};
    tick();
    bus_if.gec_resp_valid = 1'b0;
    chk("pw_r1_resp",   bus_if.csb_resp_pd, 34'h0_0000_0011);
    chk("pw_r1_vld",    bus_if.csb_resp_valid, 1);
    chk("pw_r2_release", bus_if.gec_req_pvld, 1);
    tick();
    chk("pw_r2_popped", bus_if.gec_req_pvld, 0);
    bus_if.gec_resp_valid = 1'b1;
    bus_if.gec_resp_pd    = {2'b00, 32'h0000_0022};
    tick();
    bus_if.gec_resp_valid = 1'b0;
    chk("pw_r2_vld", bus_if.csb_resp_valid, 1);
    chk("pw_r2_resp", bus_if.csb_resp_pd, 34'h0_0000_0022);
    chk("pw_cnt",    timeout_cnt, 1);
    tick();

    // Reset while waiting with two entries buffered
    bus_if.csb_req_pvld = 1'b1;
    bus_if.csb_req_pd   = mkpkt(1'b0, 1'b0, 32'h0, 22'h000101);
    tick();
    bus_if.csb_req_pd = mkpkt(1'b0, 1'b0, 32'h0, 22'h000102);
    tick();
    bus_if.csb_req_pd = mkpkt(1'b0, 1'b0, 32'h0, 22'h000103);
    tick();
    bus_if.csb_req_pvld = 1'b0;
    chk("mr_full",  bus_if.csb_req_prdy, 0);
    chk("mr_stall", bus_if.gec_req_pvld, 0);
    rstn = 1'b0;
    #1;
    chk("mr_gec_pvld", bus_if.gec_req_pvld, 0);
    chk("mr_gec_pd",   bus_if.gec_req_pd, 0);
    chk("mr_resp_vld", bus_if.csb_resp_valid, 0);
    chk("mr_resp_pd",  bus_if.csb_resp_pd, 0);
    chk("mr_tmo_cnt",  timeout_cnt, 0);
    chk("mr_prdy",     bus_if.csb_req_prdy, 1);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mr_no_resp", bus_if.csb_resp_valid, 0);
      chk("mr_no_req",  bus_if.gec_req_pvld, 0);
    end

    // Saturation of the timeout counter
    for (int i = 1; i <= 256; i++) begin
      bus_if.csb_req_pvld = 1'b1;
      bus_if.csb_req_pd   = mkpkt(1'b0, 1'b0, 32'h0, 22'(i));
      tick();
      bus_if.csb_req_pvld = 1'b0;
      tick();
      tick();
      tick();
      tick();
      tick();
      chk("sat_vld", bus_if.csb_resp_valid, 1);
      chk("sat_pd",  bus_if.csb_resp_pd, 34'h1_0000_0000);
      if (i == 255 || i == 256) begin
        chk("sat_cnt", timeout_cnt, 255);
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
